// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and H/V axis state encodings.
package vga_pkg;
  localparam int C_TOTAL_COLS  = 800;
  localparam int C_TOTAL_ROWS  = 525;
  localparam int C_ACTIVE_COLS = 640;
  localparam int C_ACTIVE_ROWS = 480;
  localparam int C_H_FRONT     = 16;
  localparam int C_H_SYNC      = 96;
  localparam int C_V_FRONT     = 10;
  localparam int C_V_SYNC      = 2;
  localparam int C_TICK_FRAMES = 6;

  localparam logic [1:0] AX_ACTIVE = 2'd0;
  localparam logic [1:0] AX_FRONT  = 2'd1;
  localparam logic [1:0] AX_SYNC   = 2'd2;
  localparam logic [1:0] AX_BACK   = 2'd3;

  localparam logic [1:0] H_ACTIVE = AX_ACTIVE;
  localparam logic [1:0] H_FRONT  = AX_FRONT;
  localparam logic [1:0] H_SYNC   = AX_SYNC;
  localparam logic [1:0] H_BACK   = AX_BACK;
  localparam logic [1:0] V_ACTIVE = AX_ACTIVE;
  localparam logic [1:0] V_FRONT  = AX_FRONT;
  localparam logic [1:0] V_SYNC   = AX_SYNC;
  localparam logic [1:0] V_BACK   = AX_BACK;

  // Transitions are keyed on the count about to be loaded, so state lines up with the count.
  function automatic logic [1:0] axis_next(input logic [1:0] st, input logic [9:0] nxt,
                                           input logic [9:0] front_at, input logic [9:0] sync_at,
                                           input logic [9:0] back_at, input logic wrap);
    logic [1:0] ns;
    ns = st;
    case (st)
      AX_ACTIVE: if (nxt == front_at) ns = AX_FRONT;
      AX_FRONT:  if (nxt == sync_at)  ns = AX_SYNC;
      AX_SYNC:   if (nxt == back_at)  ns = AX_BACK;
      default:   if (wrap)            ns = AX_ACTIVE;
    endcase
    return ns;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with enable, exposing the next count and wrap strobe.
module vga_axis_counter #(
  parameter int c_TOTAL = 800
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_En,
  output logic [9:0] o_Count,
  output logic [9:0] o_Next,
  output logic       o_Wrap
);
  localparam logic [9:0] LAST = 10'(c_TOTAL - 1);

  logic [9:0] count_q, count_d;

  always_comb begin
    o_Wrap  = i_En && (count_q == LAST);
    count_d = count_q;
    if (i_En) count_d = o_Wrap ? 10'd0 : count_q + 10'd1;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) count_q <= 10'd0;
    else         count_q <= count_d;
  end

  assign o_Count = count_q;
  assign o_Next  = count_d;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/timing generator; optional frame counter and game tick under VGA_FRAME_CNT_EN.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int c_TOTAL_COLS  = C_TOTAL_COLS,
  parameter int c_TOTAL_ROWS  = C_TOTAL_ROWS,
  parameter int c_ACTIVE_COLS = C_ACTIVE_COLS,
  parameter int c_ACTIVE_ROWS = C_ACTIVE_ROWS,
  parameter int c_H_FRONT     = C_H_FRONT,
  parameter int c_H_SYNC      = C_H_SYNC,
  parameter int c_V_FRONT     = C_V_FRONT,
`ifdef VGA_FRAME_CNT_EN
  parameter int c_TICK_FRAMES = C_TICK_FRAMES,
`endif
  parameter int c_V_SYNC      = C_V_SYNC
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_HSync_n,
  output logic       o_VSync_n,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
`ifdef VGA_FRAME_CNT_EN
  output logic [7:0] o_Frame_Cnt,
  output logic       o_Game_Tick,
`endif
  output logic       o_Frame_Start
);
  localparam logic [9:0] H_FRONT_AT = 10'(c_ACTIVE_COLS);
  localparam logic [9:0] H_SYNC_AT  = 10'(c_ACTIVE_COLS + c_H_FRONT);
  localparam logic [9:0] H_BACK_AT  = 10'(c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC);
  localparam logic [9:0] V_FRONT_AT = 10'(c_ACTIVE_ROWS);
  localparam logic [9:0] V_SYNC_AT  = 10'(c_ACTIVE_ROWS + c_V_FRONT);
  localparam logic [9:0] V_BACK_AT  = 10'(c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC);

  logic [9:0] col_next, row_next;
  logic       h_wrap, v_wrap;
  logic [1:0] h_state_q, h_state_d, v_state_q, v_state_d;
  logic       hsync_q, vsync_q, hsync_n_q, vsync_n_q, active_q, frame_q, frame_d;

  vga_axis_counter #(.c_TOTAL(c_TOTAL_COLS)) u_h (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_En(1'b1),
    .o_Count(o_Col_Count), .o_Next(col_next), .o_Wrap(h_wrap)
  );

  vga_axis_counter #(.c_TOTAL(c_TOTAL_ROWS)) u_v (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_En(h_wrap),
    .o_Count(o_Row_Count), .o_Next(row_next), .o_Wrap(v_wrap)
  );

  always_comb begin
    h_state_d = axis_next(h_state_q, col_next, H_FRONT_AT, H_SYNC_AT, H_BACK_AT, h_wrap);
    v_state_d = v_state_q;
    if (h_wrap) v_state_d = axis_next(v_state_q, row_next, V_FRONT_AT, V_SYNC_AT, V_BACK_AT, v_wrap);
    frame_d   = h_wrap && v_wrap;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      h_state_q <= H_ACTIVE;
      v_state_q <= V_ACTIVE;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      active_q  <= 1'b1;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      hsync_q   <= (h_state_d == H_ACTIVE);
      vsync_q   <= (v_state_d == V_ACTIVE);
      active_q  <= (h_state_d == H_ACTIVE) && (v_state_d == V_ACTIVE);
      hsync_n_q <= (h_state_d != H_SYNC);
      vsync_n_q <= (v_state_d != V_SYNC);
      frame_q   <= frame_d;
    end
  end

  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Active      = active_q;
  assign o_HSync_n     = hsync_n_q;
  assign o_VSync_n     = vsync_n_q;
  assign o_Frame_Start = frame_q;

`ifdef VGA_FRAME_CNT_EN
  localparam logic [7:0] TICK_LAST = 8'(c_TICK_FRAMES - 1);

  logic [7:0] frame_cnt_q, tick_div_q;
  logic       tick_q;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      frame_cnt_q <= 8'd0;
      tick_div_q  <= 8'd0;
      tick_q      <= 1'b0;
    end else begin
      tick_q <= frame_d && (tick_div_q == TICK_LAST);
      if (frame_d) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        tick_div_q  <= (tick_div_q == TICK_LAST) ? 8'd0 : tick_div_q + 8'd1;
      end
    end
  end

  assign o_Frame_Cnt = frame_cnt_q;
  assign o_Game_Tick = tick_q;
`endif
endmodule
